// File: rtl/rs_flag_bank.sv
// -----------------------------------------------------------------------------
// rs_flag_bank
//
// Bank of N independent clocked set/reset flags. It collects ready/done style
// status bits (UART TX/RX, timer) into one word for port-mapped I/O reads.
// Each channel can optionally record a sticky "rise pending" bit. Software
// acknowledges that bit with a write-1-to-clear strobe. The bank can also
// raise a registered, maskable interrupt.
//
// Build option:
//   RS_FLAG_IRQ_EN  defined     : pending bits, ack logic and irq are built.
//                   not defined : pend and irq are tied to 0, and
//                                 ack_we/ack_data/irq_mask are ignored.
//                                 The q path is identical in both builds.
//
// Parameters:
//   N            number of flag channels (1..32)
//   RESET_VAL    per-channel value of q while reset is asserted
//   SET_PRIORITY 1: set wins when set and clr coincide, 0: clr wins
//   EDGE_SET     1: a channel sets only on a rising edge of its set bit
//                0: set is level sensitive
//
// Ports:
//   clk       system clock
//   reset     asynchronous, active-high reset
//   set       per-channel set request
//   clr       per-channel clear request
//   ack_we    write strobe for pending acknowledge
//   ack_data  write-1-to-clear mask for pend, used when ack_we = 1
//   irq_mask  per-channel interrupt enable
//   q         flag state
//   pend      sticky rise-pending bits
//   irq       registered interrupt request
// -----------------------------------------------------------------------------
module rs_flag_bank #(
  parameter int unsigned    N            = 8,
  parameter logic [N-1:0]   RESET_VAL    = {N{1'b1}},
  parameter bit             SET_PRIORITY = 1'b1,
  parameter bit             EDGE_SET     = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] set,
  input  logic [N-1:0] clr,
  input  logic         ack_we,
  input  logic [N-1:0] ack_data,
  input  logic [N-1:0] irq_mask,
  output logic [N-1:0] q,
  output logic [N-1:0] pend,
  output logic         irq
);

  logic [N-1:0] s_eff;
  logic [N-1:0] q_reg;
  logic [N-1:0] q_next;

  // ---------------------------------------------------------------------------
  // Per-channel effective set and next-state selection
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_chan
      if (EDGE_SET) begin : g_edge
        // Set history clears on reset. The first set seen after reset
        // therefore counts as a rising edge.
        logic set_d_reg;

        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            set_d_reg <= 1'b0;
          end else begin
            set_d_reg <= set[gi];
          end
        end

        assign s_eff[gi] = set[gi] & ~set_d_reg;
      end else begin : g_level
        assign s_eff[gi] = set[gi];
      end

      logic chan_next;

      always_comb begin
        chan_next = q_reg[gi];
        case ({s_eff[gi], clr[gi]})
          2'b10:   chan_next = 1'b1;
          2'b01:   chan_next = 1'b0;
          2'b11:   chan_next = SET_PRIORITY;
          default: chan_next = q_reg[gi];
        endcase
      end

      assign q_next[gi] = chan_next;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Flag state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_reg <= RESET_VAL;
    end else begin
      q_reg <= q_next;
    end
  end

  assign q = q_reg;

`ifdef RS_FLAG_IRQ_EN
  // ---------------------------------------------------------------------------
  // Sticky pending bits and interrupt
  // ---------------------------------------------------------------------------
  logic [N-1:0] rise;
  logic [N-1:0] ack_clr;
  logic [N-1:0] pend_reg;
  logic [N-1:0] pend_next;
  logic         irq_reg;
  logic         irq_next;

  // Only a true 0->1 transition of q counts. A set request on a flag that is
  // already high leaves pend alone.
  assign rise    = ~q_reg & q_next;
  assign ack_clr = {N{ack_we}} & ack_data;

  // A rise in the same cycle as an ack wins, so the new event is not lost.
  assign pend_next = rise | (pend_reg & ~ack_clr);

  // irq is built from next-state. It therefore changes on the same edge as
  // pend, both when a bit is set and when an ack clears it.
  assign irq_next = |(pend_next & irq_mask);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_reg <= '0;
      irq_reg  <= 1'b0;
    end else begin
      pend_reg <= pend_next;
      irq_reg  <= irq_next;
    end
  end

  assign pend = pend_reg;
  assign irq  = irq_reg;
`else
  // In this build the acknowledge and mask inputs have no function.
  logic unused_irq_inputs;
  assign unused_irq_inputs = ^{ack_we, ack_data, irq_mask};

  assign pend = '0;
  assign irq  = 1'b0;
`endif

endmodule

// File: tb/tb_rs_flag_bank.sv
// -----------------------------------------------------------------------------
// tb_rs_flag_bank
//
// Directed bench for rs_flag_bank. Three instances share one stimulus stream:
//   u_sp1  : SET_PRIORITY=1, level set
//   u_sp0  : SET_PRIORITY=0, level set
//   u_edge : SET_PRIORITY=1, EDGE_SET=1
// Expected pend/irq values follow RS_FLAG_IRQ_EN. When the macro is not
// defined they are always 0.
// -----------------------------------------------------------------------------
module tb_rs_flag_bank;

`ifdef RS_FLAG_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] set;
  logic [7:0] clr;
  logic       ack_we;
  logic [7:0] ack_data;
  logic [7:0] irq_mask;

  logic [7:0] q_a, q_b, q_c;
  logic [7:0] pend_a, pend_b, pend_c;
  logic       irq_a, irq_b, irq_c;

  int total;
  int bad;

  rs_flag_bank #(.N(8), .RESET_VAL(8'hFF), .SET_PRIORITY(1'b1), .EDGE_SET(1'b0)) u_sp1 (
    .clk(clk), .reset(reset), .set(set), .clr(clr), .ack_we(ack_we),
    .ack_data(ack_data), .irq_mask(irq_mask), .q(q_a), .pend(pend_a), .irq(irq_a)
  );

  rs_flag_bank #(.N(8), .RESET_VAL(8'hFF), .SET_PRIORITY(1'b0), .EDGE_SET(1'b0)) u_sp0 (
    .clk(clk), .reset(reset), .set(set), .clr(clr), .ack_we(ack_we),
    .ack_data(ack_data), .irq_mask(irq_mask), .q(q_b), .pend(pend_b), .irq(irq_b)
  );

  rs_flag_bank #(.N(8), .RESET_VAL(8'hFF), .SET_PRIORITY(1'b1), .EDGE_SET(1'b1)) u_edge (
    .clk(clk), .reset(reset), .set(set), .clr(clr), .ack_we(ack_we),
    .ack_data(ack_data), .irq_mask(irq_mask), .q(q_c), .pend(pend_c), .irq(irq_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] pe(input logic [7:0] v);
    return IRQ_ON ? v : 8'h00;
  endfunction

  function automatic logic ie(input logic v);
    return IRQ_ON ? v : 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One call checks every output of all three instances after one transaction.
  task automatic check_all(input string tag,
                           input logic [7:0] qa, input logic [7:0] qb, input logic [7:0] qc,
                           input logic [7:0] pa, input logic [7:0] pb, input logic [7:0] pc,
                           input logic ia, input logic ib, input logic ic);
    $display("%s: set=%h clr=%h ack=%b/%h mask=%h | q=%h/%h/%h pend=%h/%h/%h irq=%b%b%b",
             tag, set, clr, ack_we, ack_data, irq_mask, q_a, q_b, q_c,
             pend_a, pend_b, pend_c, irq_a, irq_b, irq_c);
    chk({tag, " q_sp1"},    q_a, qa);
    chk({tag, " q_sp0"},    q_b, qb);
    chk({tag, " q_edge"},   q_c, qc);
    chk({tag, " pend_sp1"}, pend_a, pe(pa));
    chk({tag, " pend_sp0"}, pend_b, pe(pb));
    chk({tag, " pend_edge"},pend_c, pe(pc));
    chk({tag, " irq_sp1"},  {7'd0, irq_a}, {7'd0, ie(ia)});
    chk({tag, " irq_sp0"},  {7'd0, irq_b}, {7'd0, ie(ib)});
    chk({tag, " irq_edge"}, {7'd0, irq_c}, {7'd0, ie(ic)});
  endtask

  // Advance one clock and sample just after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    reset    = 1'b1;
    set      = 8'h00;
    clr      = 8'h00;
    ack_we   = 1'b0;
    ack_data = 8'h00;
    irq_mask = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_all("reset", 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 0, 0, 0);

    // Clear bit 0.
    clr = 8'h01; step(); clr = 8'h00;
    check_all("clr0", 8'hFE, 8'hFE, 8'hFE, 8'h00, 8'h00, 8'h00, 0, 0, 0);

    // Set and clear together: the priority decides. Mask is off, so no irq.
    set = 8'h01; clr = 8'h01; step(); set = 8'h00; clr = 8'h00;
    check_all("set+clr", 8'hFF, 8'hFE, 8'hFF, 8'h01, 8'h00, 8'h01, 0, 0, 0);

    // Enabling the mask raises irq on the next edge.
    irq_mask = 8'h01; step();
    check_all("mask_on", 8'hFF, 8'hFE, 8'hFF, 8'h01, 8'h00, 8'h01, 1, 0, 1);

    // Acknowledge bit 0.
    ack_we = 1'b1; ack_data = 8'h01; step(); ack_we = 1'b0; ack_data = 8'h00;
    check_all("ack0", 8'hFF, 8'hFE, 8'hFF, 8'h00, 8'h00, 8'h00, 0, 0, 0);

    clr = 8'h01; step(); clr = 8'h00;
    check_all("clr0b", 8'hFE, 8'hFE, 8'hFE, 8'h00, 8'h00, 8'h00, 0, 0, 0);

    // Set: q, pend and irq all change on the same edge.
    set = 8'h01; step(); set = 8'h00;
    check_all("set0", 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h01, 8'h01, 1, 1, 1);

    // Clear q. ack_data without ack_we must not clear pend.
    clr = 8'h01; ack_data = 8'h01; step(); clr = 8'h00; ack_data = 8'h00;
    check_all("clr_noack", 8'hFE, 8'hFE, 8'hFE, 8'h01, 8'h01, 8'h01, 1, 1, 1);

    // A rise and an ack in the same cycle: the rise wins.
    set = 8'h01; ack_we = 1'b1; ack_data = 8'h01; step();
    set = 8'h00; ack_we = 1'b0; ack_data = 8'h00;
    check_all("collide", 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h01, 8'h01, 1, 1, 1);

    // Acking the last unmasked bit drops irq on the same edge.
    ack_we = 1'b1; ack_data = 8'h01; step(); ack_we = 1'b0; ack_data = 8'h00;
    check_all("ack_last", 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 0, 0, 0);

    // A set while q is already 1 is not a rise.
    set = 8'h01; step(); set = 8'h00;
    check_all("set_high", 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 0, 0, 0);

    // Edge scenario on channel 1. Start with q[1]=0.
    clr = 8'h02; step(); clr = 8'h00;
    check_all("e_clr", 8'hFD, 8'hFD, 8'hFD, 8'h00, 8'h00, 8'h00, 0, 0, 0);

    set = 8'h02; step();
    check_all("e_c1", 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h02, 8'h02, 0, 0, 0);
    step();
    check_all("e_c2", 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h02, 8'h02, 0, 0, 0);
    clr = 8'h02; step(); clr = 8'h00;
    check_all("e_c3", 8'hFF, 8'hFD, 8'hFD, 8'h02, 8'h02, 8'h02, 0, 0, 0);
    step();
    check_all("e_c4", 8'hFF, 8'hFF, 8'hFD, 8'h02, 8'h02, 8'h02, 0, 0, 0);
    step();
    check_all("e_c5", 8'hFF, 8'hFF, 8'hFD, 8'h02, 8'h02, 8'h02, 0, 0, 0);
    set = 8'h00; step();
    check_all("e_drop", 8'hFF, 8'hFF, 8'hFD, 8'h02, 8'h02, 8'h02, 0, 0, 0);
    set = 8'h02; step(); set = 8'h00;
    check_all("e_rise", 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h02, 8'h02, 0, 0, 0);

    // Masking left pend alone. Unmasking bit 1 raises irq next edge.
    irq_mask = 8'h02; step();
    check_all("mask1", 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h02, 8'h02, 1, 1, 1);
    ack_we = 1'b1; ack_data = 8'h02; step(); ack_we = 1'b0; ack_data = 8'h00;
    check_all("ack1", 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 0, 0, 0);

    // Build up a non-reset state, then reset between clock edges.
    irq_mask = 8'h03;
    clr = 8'h0F; step(); clr = 8'h00;
    check_all("pre_clr", 8'hF0, 8'hF0, 8'hF0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    set = 8'h01; step(); set = 8'h00;
    check_all("pre_set", 8'hF1, 8'hF1, 8'hF1, 8'h01, 8'h01, 8'h01, 1, 1, 1);
    #2 reset = 1'b1;
    #1;
    check_all("async_rst", 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    #2 reset = 1'b0;
    clr = 8'h01; step(); clr = 8'h00;
    check_all("post_rst", 8'hFE, 8'hFE, 8'hFE, 8'h00, 8'h00, 8'h00, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rs_flag_bank.md
# rs_flag_bank

Parametrised bank of N clocked set/reset flags with configurable reset values, selectable set/clear priority, optional rising-edge qualification of set inputs, and an optional sticky rise-pending and interrupt path. It generalises the single TXRDY-style flop. One instance collects the ready and done flags of the UART TX/RX and timer blocks into one word for the Tramelblaze port-mapped I/O space. Software reads `q` and `pend`, and acknowledges pending bits through a write strobe.

## Interface
- `N`, 8, number of flag channels (1..32)
- `RESET_VAL`, {N{1'b1}}, per-channel value loaded into `q` on reset
- `SET_PRIORITY`, 1, 1 = set wins when set and clear coincide; 0 = clear wins
- `EDGE_SET`, 0, 1 = a channel sets only on a rising edge of its `set` bit; 0 = level-sensitive

- `clk`  in  1  system clock
- `reset`  in  1  reset, asynchronous, active-high
- `set`  in  N  per-channel set request (DONE-type events)
- `clr`  in  N  per-channel clear request (LOAD-type events)
- `ack_we`  in  1  write strobe for pending acknowledge
- `ack_data`  in  N  write-1-to-clear mask for `pend`, sampled when `ack_we`=1
- `irq_mask`  in  N  per-channel interrupt enable
- `q`  out  N  flag state
- `pend`  out  N  sticky rise-pending bits
- `irq`  out  1  registered interrupt request

## Operation
- Reset (asynchronous) gives: `q`=RESET_VAL, `pend`=0, `irq`=0, edge-detect history = 0.
- Effective set: `s_eff[i]` = `set[i]` when EDGE_SET=0. When EDGE_SET=1, `s_eff[i]` = `set[i] & ~set_d[i]`, where `set_d` is `set` registered each cycle.
- Per channel, on each rising clk edge:
  - `s_eff` only: `q`←1
  - `clr` only: `q`←0
  - both: `q`←SET_PRIORITY
  - neither: hold
- Rise detect: `rise[i]` = `~q[i] & q_next[i]`. It fires only on a 0→1 transition. A set request while `q` is already 1 does not fire it.
- Pending, per channel:
  - `rise` sets `pend[i]`.
  - `ack_we & ack_data[i]` clears `pend[i]`.
  - If a rise and an ack hit the same cycle, the rise wins and `pend` stays 1.
- `irq` ← |(`pend_next` & `irq_mask`), registered.
- Channels are fully independent. No cross-channel interaction exists.

## Timing
- `q` changes on the first clk edge that samples the request: 1-cycle latency.
- With EDGE_SET=1, a `set` bit held high for many cycles sets `q` once. A later `clr` is not undone until `set` drops and rises again.
- On an EDGE_SET=1 channel, the first `set`=1 sampled after reset counts as an edge, because `set_d` resets to 0.
- `pend` updates on the same edge as `q`.
- `irq` asserts on that same edge, since it is computed from next-state. Latency from request to `irq` is 1 cycle.
- `irq_mask` changes affect `irq` on the next edge. Masking never clears `pend`.
- An ack that clears the last unmasked pending bit deasserts `irq` on the same edge.
- Reset mid-operation forces the reset state immediately, regardless of `clk`.

## Configuration
- `RS_FLAG_IRQ_EN` defined: pending registers, ack logic and `irq` are built as described above.
- Not defined:
  - `pend` is tied to 0 and `irq` is tied to 0.
  - `ack_we`, `ack_data` and `irq_mask` are ignored.
  - No pending or irq flops are synthesised.
  - `q` behaviour is unchanged.

## Test plan
All scenarios use N=8, RESET_VAL=8'hFF and SET_PRIORITY=1, with the macro defined unless noted.
- Assert and release reset mid-run → `q`=8'hFF, `pend`=0, `irq`=0 immediately. Then pulse `clr`=8'h01 for 1 cycle → `q`=8'hFE on the next edge.
- From `q`=8'hFE, pulse `set`=8'h01 and `clr`=8'h01 together → `q`=8'hFF. Repeat with SET_PRIORITY=0 → `q`=8'hFE.
- From `q`=8'hFE with `irq_mask`=8'h01, pulse `set`=8'h01 → `q`=8'hFF, `pend`=8'h01 and `irq`=1 on the same edge. Then `ack_we`=1 with `ack_data`=8'h01 → `pend`=0 and `irq`=0 on the next edge.
- Ack collision: `q`=8'hFE, `pend`=8'h01, then `set`=8'h01 together with an ack of 8'h01 → `pend` stays 8'h01.
- EDGE_SET=1: hold `set`=8'h02 high for 5 cycles while pulsing `clr`=8'h02 at cycle 3 → `q[1]` goes 1, then 0 at cycle 3, and stays 0. Drop `set`, then raise it → `q[1]`=1.
- Macro undefined, same stimulus as the third scenario → `q`=8'hFF, while `pend`=0 and `irq`=0 throughout.
